collision_manager: RTL and testbench

- Parametrised successor to the single-ship collision logic. Resolves ship/bullet/rock collisions for NB bullets and NR rocks during the raster scan.
- Hits are accumulated per frame in sticky flags and applied once per frame at frame_end: object resets, score, lives, post-hit invulnerability and game-over.
- Sits between the object sprite generators (pixel inputs, reset outputs) and the HUD/score display. Runs on the pixel clock.

---
 rtl/asteroids_pkg.sv | 13 +
 rtl/hit_popcount.sv | 13 +
 rtl/collision_manager.sv | 96 +++++++++
 tb/tb_collision_manager.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// asteroids_pkg: shared screen limits, object index map and collision FSM states.
package asteroids_pkg;
  localparam int H_LIMIT = 660;
  localparam int V_LIMIT = 500;
  localparam int SHIP_IDX = 0;
  localparam int BULLET_BASE = 1;
  localparam int DEF_NB = 4;
  localparam int ROCK_BASE = 1 + DEF_NB;
  function automatic int rock_base(input int nb);
    return 1 + nb;
  endfunction
  typedef enum logic [1:0] {PLAY, RESOLVE, GAME_OVER} state_t;
endpackage

// File: rtl/hit_popcount.sv
// hit_popcount: combinational population count of an N-bit hit vector.
module hit_popcount #(
  parameter int N  = 10,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) count_o = count_o + CW'(bits_i[i]);
  end
endmodule

// File: rtl/collision_manager.sv
// collision_manager: accumulates ship/bullet/rock collisions per frame and applies
// respawns, score, lives, invulnerability and game-over once per frame.
module collision_manager
  import asteroids_pkg::*;
#(
  parameter int NB            = 4,
  parameter int NR            = 10,
  parameter int SCORE_W       = 16,
  parameter int LIVES_W       = 2,
  parameter int START_LIVES   = 3,
  parameter int ROCK_POINTS   = 1,
  parameter int INVULN_FRAMES = 60,
  parameter int H_LIMIT       = asteroids_pkg::H_LIMIT,
  parameter int V_LIMIT       = asteroids_pkg::V_LIMIT
) (
  input  logic                 clk,
  input  logic                 reset_game,
  input  logic                 frame_end,
  input  logic [9:0]           px,
  input  logic [9:0]           py,
  input  logic                 ship_pix,
  input  logic [NB-1:0]        bullet_pix,
  input  logic [NR-1:0]        rock_pix,
  output logic [NB+NR:0]       obj_reset,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives,
  output logic                 invulnerable,
  output logic                 ship_hit,
  output logic                 game_over
);
  localparam int NO = 1 + NB + NR;
  localparam int CW = $clog2(NR + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 2);
  localparam int SW = SCORE_W + 33;
  state_t state_q, state_d;
  logic [NB-1:0] bhit_q, bhit_d;
  logic [NR-1:0] rhit_q, rhit_d, rkill_q, rkill_d;
  logic [NO-1:0] offs_q, offs_d;
  logic shit_q, shit_d, rst_pend_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [IW-1:0] inv_q, inv_d;
  logic [CW-1:0] rcnt;
  logic [SW-1:0] sum;
  logic accum, resolve, on, ship_en, last;
  hit_popcount #(.N(NR), .CW(CW)) u_pop (.bits_i(rhit_q), .count_o(rcnt));
  always_comb begin
    accum   = state_q == PLAY;
    resolve = state_q == RESOLVE;
    on      = (px < 10'(H_LIMIT)) && (py < 10'(V_LIMIT));
    ship_en = on && inv_q == '0;
    bhit_d  = accum ? bhit_q | ({NB{on & |rock_pix}} & bullet_pix) : '0;
    rhit_d  = accum ? rhit_q | ({NR{on & |bullet_pix}} & rock_pix) : '0;
    rkill_d = accum ? rkill_q | ({NR{ship_en & ship_pix}} & rock_pix) : '0;
    shit_d  = accum & (shit_q | (ship_en & ship_pix & |rock_pix));
    offs_d  = accum ? offs_q | ({NO{~on}} & {rock_pix, bullet_pix, ship_pix}) : '0;
    last    = shit_q && lives_q == LIVES_W'(1);
    state_d = resolve ? (last ? GAME_OVER : PLAY) : (accum && frame_end) ? RESOLVE : state_q;
    sum     = SW'(score_q) + SW'(ROCK_POINTS) * SW'(rcnt);
    score_d = !resolve ? score_q : |sum[SW-1:SCORE_W] ? '1 : sum[SCORE_W-1:0];
    lives_d = (resolve && shit_q) ? lives_q - LIVES_W'(1) : lives_q;
    inv_d   = !resolve ? inv_q : shit_q ? IW'(INVULN_FRAMES) : (inv_q != '0) ? inv_q - IW'(1) : inv_q;
  end
  always_ff @(posedge clk or posedge reset_game) begin
    if (reset_game) begin
      state_q    <= PLAY;
      bhit_q     <= '0;
      rhit_q     <= '0;
      rkill_q    <= '0;
      offs_q     <= '0;
      shit_q     <= 1'b0;
      rst_pend_q <= 1'b1;
      score_q    <= '0;
      lives_q    <= LIVES_W'(START_LIVES);
      inv_q      <= '0;
    end else begin
      state_q    <= state_d;
      bhit_q     <= bhit_d;
      rhit_q     <= rhit_d;
      rkill_q    <= rkill_d;
      offs_q     <= offs_d;
      shit_q     <= shit_d;
      rst_pend_q <= 1'b0;
      score_q    <= score_d;
      lives_q    <= lives_d;
      inv_q      <= inv_d;
    end
  end
  // Respawn pulses are all-ones while the post-reset edge is pending.
  assign obj_reset    = resolve ? ({rhit_q | rkill_q, bhit_q, shit_q} | offs_q) : {NO{rst_pend_q}};
  assign score        = score_q;
  assign lives        = lives_q;
  assign invulnerable = inv_q != '0;
  assign ship_hit     = resolve & shit_q;
  assign game_over    = state_q == GAME_OVER;
endmodule

// File: tb/tb_collision_manager.sv
// tb_collision_manager: directed checks of collision resolution, lives, invulnerability and saturation.
module tb_collision_manager;
  logic clk = 0, reset_game = 0, frame_end = 0, ship_pix = 0;
  logic [9:0] px = 10'd100, py = 10'd100;
  logic [3:0] bullet_pix = '0;
  logic [9:0] rock_pix = '0;
  logic [14:0] obj_reset, obj_reset2;
  logic [15:0] score;
  logic [1:0] score2, lives, lives2;
  logic invulnerable, ship_hit, game_over, inv2, ship_hit2, game_over2;
  int tests = 0, fails = 0;
  collision_manager dut (
    .clk(clk), .reset_game(reset_game), .frame_end(frame_end), .px(px), .py(py),
    .ship_pix(ship_pix), .bullet_pix(bullet_pix), .rock_pix(rock_pix),
    .obj_reset(obj_reset), .score(score), .lives(lives), .invulnerable(invulnerable),
    .ship_hit(ship_hit), .game_over(game_over));
  collision_manager #(.SCORE_W(2)) d2 (
    .clk(clk), .reset_game(reset_game), .frame_end(frame_end), .px(px), .py(py),
    .ship_pix(ship_pix), .bullet_pix(bullet_pix), .rock_pix(rock_pix),
    .obj_reset(obj_reset2), .score(score2), .lives(lives2), .invulnerable(inv2),
    .ship_hit(ship_hit2), .game_over(game_over2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic pix(input logic s, input logic [3:0] b, input logic [9:0] r, input int n);
    ship_pix = s;
    bullet_pix = b;
    rock_pix = r;
    repeat (n) step;
    ship_pix = 0;
    bullet_pix = '0;
    rock_pix = '0;
  endtask
  task automatic frame;
    frame_end = 1;
    step;
    frame_end = 0;
  endtask
  initial begin
    #1 reset_game = 1;
    #3;
    chk("rst_obj", 32'(obj_reset), 32'h7FFF);
    chk("rst_score", 32'(score), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_go", 32'(game_over), 0);
    chk("rst_inv", 32'(invulnerable), 0);
    chk("rst_hit", 32'(ship_hit), 0);
    chk("rst_obj2", 32'(obj_reset2), 32'h7FFF);
    #3 reset_game = 0;
    step;
    chk("rel_obj", 32'(obj_reset), 0);
    pix(0, 4'b0100, 10'h020, 3);
    chk("acc_obj", 32'(obj_reset), 0);
    frame;
    chk("b2r5_obj", 32'(obj_reset), 32'h0408);
    chk("b2r5_hit", 32'(ship_hit), 0);
    step;
    chk("b2r5_score", 32'(score), 1);
    chk("b2r5_obj0", 32'(obj_reset), 0);
    pix(0, 4'b0011, 10'h081, 1);
    frame;
    chk("two_obj", 32'(obj_reset), 32'h1026);
    step;
    chk("two_score", 32'(score), 3);
    chk("two_score2", 32'(score2), 3);
    pix(0, 4'b1000, 10'h200, 1);
    frame;
    chk("b3r9_obj", 32'(obj_reset), 32'h4010);
    step;
    chk("b3r9_score", 32'(score), 4);
    chk("sat_score2", 32'(score2), 3);
    pix(1, 4'b0000, 10'h008, 1);
    frame;
    chk("ship1_obj", 32'(obj_reset), 32'h0101);
    chk("ship1_hit", 32'(ship_hit), 1);
    chk("ship1_lives_r", 32'(lives), 3);
    step;
    chk("ship1_lives", 32'(lives), 2);
    chk("ship1_hit0", 32'(ship_hit), 0);
    chk("ship1_score", 32'(score), 4);
    chk("ship1_inv", 32'(invulnerable), 1);
    for (int k = 1; k <= 60; k++) begin
      if (k == 30) pix(1, 4'b0000, 10'h008, 2);
      frame;
      if (k == 30) begin
        chk("inv_obj", 32'(obj_reset), 0);
        chk("inv_hit", 32'(ship_hit), 0);
      end
      step;
      if (k == 59) chk("inv_59", 32'(invulnerable), 1);
      if (k == 60) begin
        chk("inv_60", 32'(invulnerable), 0);
        chk("inv_lives", 32'(lives), 2);
      end
    end
    px = 10'd662;
    pix(0, 4'b0000, 10'h010, 1);
    px = 10'd100;
    frame;
    chk("offs_obj", 32'(obj_reset), 32'h0200);
    step;
    chk("offs_score", 32'(score), 4);
    chk("offs_lives", 32'(lives), 2);
    pix(1, 4'b0000, 10'h002, 1);
    frame;
    chk("ship2_obj", 32'(obj_reset), 32'h0041);
    step;
    chk("ship2_lives", 32'(lives), 1);
    chk("ship2_go", 32'(game_over), 0);
    repeat (60) begin
      frame;
      step;
    end
    chk("ship2_inv", 32'(invulnerable), 0);
    pix(1, 4'b0000, 10'h004, 1);
    frame;
    chk("ship3_obj", 32'(obj_reset), 32'h0081);
    chk("ship3_hit", 32'(ship_hit), 1);
    step;
    chk("ship3_lives", 32'(lives), 0);
    chk("ship3_go", 32'(game_over), 1);
    chk("ship3_go2", 32'(game_over2), 1);
    chk("ship3_lives2", 32'(lives2), 0);
    pix(0, 4'b0001, 10'h001, 2);
    frame;
    chk("go_obj", 32'(obj_reset), 0);
    chk("go_hit", 32'(ship_hit), 0);
    step;
    chk("go_score", 32'(score), 4);
    chk("go_lives", 32'(lives), 0);
    chk("go_hold", 32'(game_over), 1);
    reset_game = 1;
    #2;
    chk("rst2_go", 32'(game_over), 0);
    chk("rst2_lives", 32'(lives), 3);
    #2 reset_game = 0;
    step;
    pix(0, 4'b0100, 10'h020, 2);
    #2 reset_game = 1;
    #2 reset_game = 0;
    chk("mid_obj", 32'(obj_reset), 32'h7FFF);
    step;
    frame;
    chk("mid_res_obj", 32'(obj_reset), 0);
    step;
    chk("mid_score", 32'(score), 0);
    chk("mid_inv2", 32'(inv2), 0);
    chk("mid_hit2", 32'(ship_hit2), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
